load_store_unit: RTL and testbench



---
 rtl/load_store_unit.sv | 188 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-wide, byte-addressed data
// memory. Big-endian lane order, alignment checking, sign/zero-extended loads
// and read-modify-write for byte/halfword stores. One response per request.
module load_store_unit #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_adress,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_size;
    logic                r_signed;
    logic                r_write;
    logic                r_err;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_merge;
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic                r_resp_err;

    logic                w_accept;
    logic                w_req_err;
    logic                w_subword_st;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [DATA_W-1:0]   w_load;
    logic [DATA_W-1:0]   w_merged;

    assign req_ready    = (r_state == IDLE);
    assign w_accept     = req_valid && req_ready;
    assign w_req_err    = (req_size == 2'b11) ||
                          (req_size == SZ_HALF && req_addr[0]) ||
                          (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
    // Sub-word stores need the old word first, so they take the RMW path.
    assign w_subword_st = r_write && !r_err && (r_size != SZ_WORD);

    // Memory address is always the word-aligned latched address.
    assign mem_adress = {r_addr[ADDR_W-1:2], 2'b00};

    // Latch the request on acceptance; the error verdict is decided here too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_wdata  <= '0;
        end else if (w_accept) begin
            r_addr   <= req_addr;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_write  <= req_write;
            r_err    <= w_req_err;
            r_wdata  <= req_wdata;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state and memory strobes; strobes depend only on state and latched fields.
    always_comb begin
        w_next         = r_state;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_write_data = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = ACCESS;
            end
            ACCESS: begin
                w_next = IDLE;
                if (!r_err) begin
                    if (!r_write) begin
                        mem_read = 1'b1;
                    end else if (r_size == SZ_WORD) begin
                        mem_write      = 1'b1;
                        mem_write_data = r_wdata;
                    end else begin
                        mem_read = 1'b1;
                        w_next   = MERGE_WR;
                    end
                end
            end
            MERGE_WR: begin
                w_next         = IDLE;
                mem_write      = 1'b1;
                mem_write_data = w_merged;
            end
            default: w_next = IDLE;
        endcase
    end

    // Big-endian lane extraction and sign/zero extension of load data.
    always_comb begin
        w_byte = mem_read_data[7:0];
        case (r_addr[1:0])
            2'd0: w_byte = mem_read_data[31:24];
            2'd1: w_byte = mem_read_data[23:16];
            2'd2: w_byte = mem_read_data[15:8];
            2'd3: w_byte = mem_read_data[7:0];
            default: w_byte = mem_read_data[7:0];
        endcase
        w_half = r_addr[1] ? mem_read_data[15:0] : mem_read_data[31:16];
        case (r_size)
            SZ_BYTE: w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            SZ_HALF: w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = mem_read_data;
        endcase
    end

    // Replace only the addressed lane of the captured word with the store data.
    always_comb begin
        w_merged = r_merge;
        if (r_size == SZ_BYTE) begin
            case (r_addr[1:0])
                2'd0: w_merged[31:24] = r_wdata[7:0];
                2'd1: w_merged[23:16] = r_wdata[7:0];
                2'd2: w_merged[15:8]  = r_wdata[7:0];
                2'd3: w_merged[7:0]   = r_wdata[7:0];
                default: w_merged = r_merge;
            endcase
        end else if (r_addr[1]) begin
            w_merged[15:0] = r_wdata[15:0];
        end else begin
            w_merged[31:16] = r_wdata[15:0];
        end
    end

    // Capture the old word during the read half of a sub-word store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_merge <= '0;
        else if (r_state == ACCESS && w_subword_st) r_merge <= mem_read_data;
    end

    // Registered response: pulse after the last memory cycle, data held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            if (r_state == ACCESS && !w_subword_st) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= r_err;
                r_resp_rdata <= (!r_err && !r_write) ? w_load : '0;
            end else if (r_state == MERGE_WR) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= 1'b0;
                r_resp_rdata <= '0;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural word memory, table of requests with
// expected results, scoreboard queue checked on every resp_valid, plus
// hand-written reset and back-to-back sequences.
module tb_load_store_unit;

    localparam int ADDR_W = 18;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_signed = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_adress;
    logic [31:0]       mem_write_data;
    logic              mem_write;
    logic              mem_read;
    logic [31:0]       mem_read_data;

    load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_adress(mem_adress), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, write on rising edge.
    logic [31:0] mem [0:255];
    initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    assign mem_read_data = mem[mem_adress[9:2]];
    always @(posedge clk) if (mem_write) mem[mem_adress[9:2]] <= mem_write_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [17:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } sb_t;

    sb_t sb[$];
    int  n_cmp = 0;
    int  n_fail = 0;
    int  rd_cnt = 0;
    int  wr_cnt = 0;
    logic [17:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Response monitor and memory-strobe observer, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (mem_read || mem_write) chk("mem_adress_aligned", {30'd0, mem_adress[1:0]}, 32'd0);
            if (mem_read) rd_cnt++;
            if (mem_write) begin
                wr_cnt++;
                last_waddr = mem_adress;
                last_wdata = mem_write_data;
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_resp_valid", 32'd1, 32'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    chk("resp_latency", cyc - e.acc, e.lat);
                end
            end
        end
    end

    // Drive one request from just after a rising edge and register its expected response.
    task automatic issue(input vec_t v);
        int n;
        sb_t e;
        n = 0;
        @(posedge clk); #1;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("req_ready_timeout", 32'd0, 32'd1);
        req_write  = v.wr;
        req_size   = v.sz;
        req_signed = v.sg;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_valid  = 1'b1;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.lat   = (v.wr && !v.exp_err && v.sz != 2'b10) ? 3 : 2;
        e.acc   = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        // Request fields may wander once accepted.
        req_addr  = 18'($urandom);
        req_wdata = $urandom;
        req_size  = 2'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("resp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    vec_t tbl[22];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0, er, ew;
        vec_t v;
        sb_t e;

        tbl[0]  = '{1'b1, 2'b10, 1'b0, 18'h20, 32'h11223344, 32'h0, 1'b0, 32'h11223344};
        tbl[1]  = '{1'b1, 2'b10, 1'b0, 18'h30, 32'h80FF7F01, 32'h0, 1'b0, 32'h80FF7F01};
        tbl[2]  = '{1'b1, 2'b10, 1'b0, 18'h10, 32'hDEADBEEF, 32'h0, 1'b0, 32'hDEADBEEF};
        tbl[3]  = '{1'b0, 2'b10, 1'b0, 18'h10, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 2'b00, 1'b0, 18'h21, 32'hFFFFFFAB, 32'h0, 1'b0, 32'h11AB3344};
        tbl[5]  = '{1'b0, 2'b10, 1'b0, 18'h20, 32'h0, 32'h11AB3344, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 2'b00, 1'b1, 18'h31, 32'h0, 32'hFFFFFFFF, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 2'b01, 1'b0, 18'h32, 32'h0, 32'h00007F01, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 2'b00, 1'b1, 18'h30, 32'h0, 32'hFFFFFF80, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 2'b00, 1'b0, 18'h30, 32'h0, 32'h00000080, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 2'b01, 1'b1, 18'h30, 32'h0, 32'hFFFF80FF, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 2'b00, 1'b0, 18'h33, 32'h0, 32'h00000001, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 2'b00, 1'b1, 18'h32, 32'h0, 32'h0000007F, 1'b0, 32'h0};
        tbl[13] = '{1'b1, 2'b01, 1'b0, 18'h22, 32'h1234CAFE, 32'h0, 1'b0, 32'h11ABCAFE};
        tbl[14] = '{1'b1, 2'b00, 1'b0, 18'h23, 32'h00000055, 32'h0, 1'b0, 32'h11ABCA55};
        tbl[15] = '{1'b1, 2'b01, 1'b0, 18'h20, 32'h0000BEEF, 32'h0, 1'b0, 32'hBEEFCA55};
        tbl[16] = '{1'b0, 2'b10, 1'b0, 18'h22, 32'h0, 32'h0, 1'b1, 32'h0};
        tbl[17] = '{1'b1, 2'b01, 1'b0, 18'h23, 32'h77777777, 32'h0, 1'b1, 32'h0};
        tbl[18] = '{1'b0, 2'b11, 1'b0, 18'h20, 32'h0, 32'h0, 1'b1, 32'h0};
        tbl[19] = '{1'b1, 2'b10, 1'b0, 18'h21, 32'h66666666, 32'h0, 1'b1, 32'h0};
        tbl[20] = '{1'b0, 2'b01, 1'b1, 18'h21, 32'h0, 32'h0, 1'b1, 32'h0};
        tbl[21] = '{1'b0, 2'b10, 1'b0, 18'h20, 32'h0, 32'hBEEFCA55, 1'b0, 32'h0};

        // Reset values with rst_n held low.
        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_write_data", mem_write_data, 32'd0);
        chk("rst_mem_adress", {14'd0, mem_adress}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

        // Table of single requests.
        for (int i = 0; i < 22; i++) begin
            v  = tbl[i];
            r0 = rd_cnt;
            w0 = wr_cnt;
            issue(v);
            wait_done();
            er = v.exp_err ? 0 : (!v.wr ? 1 : (v.sz == 2'b10 ? 0 : 1));
            ew = (v.exp_err || !v.wr) ? 0 : 1;
            chk($sformatf("mem_read_cycles[%0d]", i), rd_cnt - r0, er);
            chk($sformatf("mem_write_cycles[%0d]", i), wr_cnt - w0, ew);
            if (v.wr && !v.exp_err) begin
                chk($sformatf("mem_wdata[%0d]", i), last_wdata, v.exp_wdata);
                chk($sformatf("mem_waddr[%0d]", i), {14'd0, last_waddr}, {14'd0, v.addr & 18'h3FFFC});
            end
        end

        // Reset in the write cycle of a byte RMW store: no commit, no response.
        v = '{1'b1, 2'b10, 1'b0, 18'h40, 32'hCAFEF00D, 32'h0, 1'b0, 32'hCAFEF00D};
        issue(v);
        wait_done();
        @(posedge clk); #1;
        req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 18'h41; req_wdata = 32'h00000099; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rmw_access_read", {31'd0, mem_read}, 32'd1);
        @(posedge clk); #1;
        chk("rmw_merge_write", {31'd0, mem_write}, 32'd1);
        chk("rmw_merge_data", mem_write_data, 32'hCA99F00D);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_mem_adress", {14'd0, mem_adress}, 32'd0);
        @(posedge clk); #1;
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_resp_rdata", resp_rdata, 32'd0);
        chk("midrst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("midrst_mem_write_data", mem_write_data, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        v = '{1'b0, 2'b10, 1'b0, 18'h40, 32'h0, 32'hCAFEF00D, 1'b0, 32'h0};
        issue(v);
        wait_done();

        // Back-to-back: req_valid held high across five loads.
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            logic [17:0] a;
            logic [31:0] x;
            logic [1:0]  s;
            logic        g;
            case (i)
                0: begin a = 18'h10; s = 2'b10; g = 1'b0; x = 32'hDEADBEEF; end
                1: begin a = 18'h20; s = 2'b10; g = 1'b0; x = 32'hBEEFCA55; end
                2: begin a = 18'h31; s = 2'b00; g = 1'b1; x = 32'hFFFFFFFF; end
                3: begin a = 18'h40; s = 2'b10; g = 1'b0; x = 32'hCAFEF00D; end
                default: begin a = 18'h22; s = 2'b01; g = 1'b0; x = 32'h0000CA55; end
            endcase
            chk($sformatf("b2b_ready[%0d]", i), {31'd0, req_ready}, 32'd1);
            req_write = 1'b0; req_size = s; req_signed = g; req_addr = a;
            req_valid = 1'b1;
            e.rdata = x; e.err = 1'b0; e.lat = 2; e.acc = cyc;
            sb.push_back(e);
            @(posedge clk); #1;
            chk($sformatf("b2b_busy[%0d]", i), {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        wait_done();
        repeat (4) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
